irda_transmitter: RTL
=====================

# irda_transmitter

Serialises one 7-bit ASCII character per request into an IrDA SIR pulse stream for the IR LED driver. It is the transmit end of the link whose receiver captures a 10-bit frame, checks parity and framing, and decodes the character onto two hex digits. The frame is start(0), 7 data bits LSB first, parity, stop(1). Each logic-0 bit is sent as a high pulse lasting 3/16 of the bit period; each logic-1 bit sends no pulse.

## Interface
Parameters:
- CLKS_PER_BIT, 5208: clk cycles per bit (50 MHz / 9600 baud); must be ≥ 4.
- PULSE_CLKS, 976: high-pulse length in cycles for a 0 bit (3/16 × CLKS_PER_BIT); must satisfy 1 ≤ PULSE_CLKS < CLKS_PER_BIT.
- PARITY_ODD, 0: 0 gives even parity (the parity bit makes the count of ones in data+parity even); 1 gives odd parity.

Ports:
- clk, in, 1: system clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- ena, in, 1: global enable; when low, every register holds its value.
- start, in, 1: level-sampled request to send data.
- data, in, 7: ASCII character; sampled only in the cycle start is accepted.
- txd_ir, out, 1: IR pulse output; 1 means LED on. Registered.
- busy, out, 1: high while a frame is in progress. Registered.
- done, out, 1: single-cycle pulse when a frame completes. Registered.

## Operation
- States:
  - IDLE → SEND when start=1, ena=1 and rst=0.
  - SEND → DONE after the last cycle of the stop bit.
  - DONE → IDLE unconditionally after one cycle.
- On accept:
  - Load the frame shift register with {1, parity, data[6:0], 0}, so bit 0 (start) goes out first.
  - Clear the baud counter (0..CLKS_PER_BIT-1) and the bit counter (0..9).
- In SEND:
  - The baud counter increments each enabled cycle.
  - At CLKS_PER_BIT-1 the baud counter wraps to 0, the shift register shifts right by one, and the bit counter increments.
  - When the bit counter is 9 and the baud counter is at CLKS_PER_BIT-1, the FSM goes to DONE.
- txd_ir is 1 when both of these hold in the current cycle: the current frame bit is 0 and the baud counter < PULSE_CLKS. Otherwise txd_ir is 0.
- Parity is computed as ^data XOR PARITY_ODD.
- busy is 1 in SEND only. done is 1 in DONE only.
- start is ignored in SEND and DONE; nothing is queued.
- data is ignored outside the accept cycle; changing it mid-frame has no effect.
- With ena=0, state, counters, shift register and all outputs hold. This applies in every state, including mid-pulse: txd_ir stays high if it was high. Timing resumes exactly where it stopped.
- rst=1 at any edge, including mid-frame, forces:
  - IDLE state, counters 0, txd_ir=0, busy=0, done=0.
  - The partial frame is abandoned. rst has priority over ena and start.

## Timing
- Reset values: txd_ir=0, busy=0, done=0, state IDLE.
- Let start be sampled high at edge E0 (IDLE, ena=1).
  - Frame occupies the N×10 cycles after E0, where N = CLKS_PER_BIT. busy=1 throughout.
  - txd_ir rises for the start pulse in the first cycle after E0 (one-cycle latency).
  - The pulse for frame bit k occupies cycles k×N+1 .. k×N+PULSE_CLKS after E0.
- done=1 and busy=0 in cycle 10N+1 after E0.
- IDLE is re-entered at cycle 10N+2. The earliest next accept is at that edge, so back-to-back frames are spaced 10N+2 cycles start-to-start.
- The idle line is low (no pulses). Stop and idle therefore look identical on txd_ir.

## Test plan
Bench parameters: CLKS_PER_BIT=16, PULSE_CLKS=3, PARITY_ODD=0. Cycle offsets are counted from the accept edge.
- Character 'A' (0x41):
  - Stimulus: start=1 for one cycle, data=7'h41.
  - Response: 3-cycle txd_ir pulses at frame bits 0,2,3,4,5,6,8 (7 pulses), starting at cycles 1,33,49,65,81,97,129. busy=1 for cycles 1..160; done=1 only at cycle 161.
- Character 'C' (0x43):
  - Response: parity bit=1; pulses only in bits 0,3,4,5,6 (5 pulses). No pulse in bit 8.
- 0x7F and 0x00:
  - 0x7F gives exactly one pulse (the start bit).
  - 0x00 gives 9 pulses (bits 0..8), none in bit 9.
  - With PARITY_ODD=1, 0x7F gives 2 pulses (bits 0 and 8).
- Ignored requests and data changes:
  - Stimulus: hold start=1 continuously with data toggling during a frame.
  - Response: exactly one frame per IDLE visit, carrying the data latched at accept. Accept edges are 162 cycles apart.
- Enable freeze:
  - Stimulus: drop ena for 10 cycles at cycle 2, mid start pulse.
  - Response: txd_ir stays 1 through the freeze, then ends at cycle 13. done is delayed to cycle 171.
- Reset mid-frame:
  - Stimulus: assert rst at cycle 50.
  - Response: next cycle txd_ir=0, busy=0, and no done. A following start gives a full, correct frame.

Source files
------------

// File: rtl/irda_transmitter_if.sv
// Request and IR-output signals shared between the character source and the IrDA SIR transmitter.
interface irda_transmitter_if;
  logic       ena;
  logic       start;
  logic [6:0] data;
  logic       txd_ir;
  logic       busy;
  logic       done;

  modport master (output ena, start, data, input txd_ir, busy, done);
  modport slave  (input ena, start, data, output txd_ir, busy, done);
endinterface

// File: rtl/irda_transmitter.sv
// IrDA SIR transmitter: sends start, 7 data bits LSB first, parity and stop.
// A 0 bit is a short high pulse at the start of its bit period; a 1 bit sends no pulse.
//
// state | meaning
// IDLE  | line quiet, waiting for start
// SEND  | shifting the 10-bit frame out, one bit per CLKS_PER_BIT cycles
// DONE  | one-cycle completion strobe, then back to IDLE
module irda_transmitter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PULSE_CLKS   = 976,
  parameter int PARITY_ODD   = 0
) (
  input logic               clk,
  input logic               rst,
  irda_transmitter_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] PULSE_LIM = BAUD_W'(PULSE_CLKS);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [3:0]        bit_cnt, bit_nxt;
  logic [9:0]        shift_reg, shift_nxt;
  logic              txd_q, txd_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              parity;

  assign parity = (^bus.data) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk) begin
    if (rst)          state <= IDLE;
    else if (bus.ena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SEND;
          shift_nxt = {1'b1, parity, bus.data, 1'b0};
          baud_nxt  = '0;
          bit_nxt   = '0;
        end
      end
      SEND: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift_reg[9:1]};
          if (bit_cnt == 4'd9) begin
            state_nxt = DONE;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Outputs are registered from next-state values so they line up with the counters they describe.
    txd_nxt  = (state_nxt == SEND) && !shift_nxt[0] && (baud_nxt < PULSE_LIM);
    busy_nxt = (state_nxt == SEND);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      txd_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.ena) begin
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      txd_q     <= txd_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.txd_ir = txd_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
